// File: rtl/gb_out_framer_pkg.sv
// Shared pixel/position types and default image geometry for the output framer.
package gb_pkg;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned IMG_W = 488;
  localparam int unsigned IMG_H = 648;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [8:0]       x_t;
  typedef logic [9:0]       y_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_cnt_e;
endpackage

// File: rtl/gb_out_framer_if.sv
// Valid/ready pixel stream bundle used between the framer and its skid FIFO.
interface gb_out_framer_if;
  gb_pkg::pix_t tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/gb_out_framer_skid_fifo.sv
// Two-entry pixel buffer; the head register drives the output so there is no
// combinational path from the input stream to the output stream.
module gb_skid_fifo (
  input logic             clk,
  input logic             rst,
  input logic             step,
  gb_out_framer_if.slave  s,
  gb_out_framer_if.master m
);
  import gb_pkg::*;

  fifo_cnt_e r_cnt, w_cnt_nxt;
  pix_t      r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic      w_push, w_pop;

  assign s.tready = rst & step & (r_cnt != FIFO_FULL);
  assign m.tvalid = rst & step & (r_cnt != FIFO_EMPTY);
  assign m.tdata  = r_head;
  assign w_push   = s.tvalid & s.tready;
  assign w_pop    = m.tvalid & m.tready;

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    unique case (r_cnt)
      FIFO_EMPTY: begin
        if (w_push) begin
          w_head_nxt = s.tdata;
          w_cnt_nxt  = FIFO_ONE;
        end
      end
      FIFO_ONE: begin
        if (w_push && w_pop) begin
          w_head_nxt = s.tdata;
        end else if (w_push) begin
          w_tail_nxt = s.tdata;
          w_cnt_nxt  = FIFO_FULL;
        end else if (w_pop) begin
          w_cnt_nxt  = FIFO_EMPTY;
        end
      end
      FIFO_FULL: begin
        if (w_pop) begin
          w_head_nxt = r_tail;
          w_cnt_nxt  = FIFO_ONE;
        end
      end
      default: w_cnt_nxt = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= FIFO_EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
    end
  end
endmodule

// File: rtl/gb_out_framer.sv
// Frames the blurred pixel stream with line/frame markers and counts frames.
// Optional per-frame checksum enabled by GB_OUT_FRAMER_CKSUM_EN.
module gb_out_framer #(
  parameter int unsigned IMG_W = gb_pkg::IMG_W,
  parameter int unsigned IMG_H = gb_pkg::IMG_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [7:0]  s_TDATA,
  input  logic        s_TVALID,
  output logic        s_TREADY,
  output logic [7:0]  m_TDATA,
  output logic        m_TVALID,
  input  logic        m_TREADY,
  output logic        m_TLAST,
  output logic        m_TUSER,
  output logic [15:0] frame_cnt
`ifdef GB_OUT_FRAMER_CKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic        frame_done
`endif
);
  import gb_pkg::*;

  localparam x_t X_LAST = x_t'(IMG_W - 1);
  localparam y_t Y_LAST = y_t'(IMG_H - 1);

  gb_out_framer_if w_s_if ();
  gb_out_framer_if w_m_if ();

  x_t          r_x;
  y_t          r_y;
  logic [15:0] r_frame_cnt;
  logic        w_pop, w_frame_end;

  assign w_s_if.tdata  = s_TDATA;
  assign w_s_if.tvalid = s_TVALID;
  assign s_TREADY      = w_s_if.tready;
  assign w_m_if.tready = m_TREADY;

  gb_skid_fifo u_fifo (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .s    (w_s_if.slave),
    .m    (w_m_if.master)
  );

  assign m_TDATA     = w_m_if.tdata;
  assign m_TVALID    = w_m_if.tvalid;
  assign m_TLAST     = w_m_if.tvalid & (r_x == X_LAST);
  assign m_TUSER     = w_m_if.tvalid & (r_x == '0) & (r_y == '0);
  assign frame_cnt   = r_frame_cnt;
  assign w_pop       = w_m_if.tvalid & m_TREADY;
  assign w_frame_end = w_pop & (r_x == X_LAST) & (r_y == Y_LAST);

  // Position tracks the pixel currently at the FIFO head, so it moves only on pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= '0;
    end else if (w_pop) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        if (r_y == Y_LAST) begin
          r_y         <= '0;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_y <= r_y + y_t'(1);
        end
      end else begin
        r_x <= r_x + x_t'(1);
      end
    end
  end

`ifdef GB_OUT_FRAMER_CKSUM_EN
  logic [15:0] r_acc, r_frame_sum;
  logic        r_frame_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc        <= '0;
      r_frame_sum  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_frame_end) begin
        r_frame_sum  <= r_acc + 16'(w_m_if.tdata);
        r_acc        <= '0;
        r_frame_done <= 1'b1;
      end else if (w_pop) begin
        r_acc <= r_acc + 16'(w_m_if.tdata);
      end
    end
  end

  assign frame_sum  = r_frame_sum;
  assign frame_done = r_frame_done;
`endif
endmodule

// File: tb/tb_gb_out_framer.sv
// Directed bench for gb_out_framer: a 4x2 instance for framing and a default
// 488x648 instance sharing the same input stimulus for long-line markers.
module tb_gb_out_framer;
  logic        clk;
  logic        rst;
  logic        step;
  logic        m_tlast, m_tuser;
  logic [15:0] frame_cnt;
  logic        d_s_tready, d_m_tvalid, d_m_tlast, d_m_tuser;
  logic [7:0]  d_m_tdata;
  logic [15:0] d_frame_cnt;
`ifdef GB_OUT_FRAMER_CKSUM_EN
  logic [15:0] frame_sum, d_frame_sum;
  logic        frame_done, d_frame_done;
`endif

  int checks   = 0;
  int failures = 0;

  gb_out_framer_if u_s_if ();
  gb_out_framer_if u_m_if ();

  gb_out_framer #(.IMG_W(4), .IMG_H(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .s_TDATA   (u_s_if.tdata),
    .s_TVALID  (u_s_if.tvalid),
    .s_TREADY  (u_s_if.tready),
    .m_TDATA   (u_m_if.tdata),
    .m_TVALID  (u_m_if.tvalid),
    .m_TREADY  (u_m_if.tready),
    .m_TLAST   (m_tlast),
    .m_TUSER   (m_tuser),
    .frame_cnt (frame_cnt)
`ifdef GB_OUT_FRAMER_CKSUM_EN
    ,
    .frame_sum (frame_sum),
    .frame_done(frame_done)
`endif
  );

  gb_out_framer dut_d (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .s_TDATA   (u_s_if.tdata),
    .s_TVALID  (u_s_if.tvalid),
    .s_TREADY  (d_s_tready),
    .m_TDATA   (d_m_tdata),
    .m_TVALID  (d_m_tvalid),
    .m_TREADY  (u_m_if.tready),
    .m_TLAST   (d_m_tlast),
    .m_TUSER   (d_m_tuser),
    .frame_cnt (d_frame_cnt)
`ifdef GB_OUT_FRAMER_CKSUM_EN
    ,
    .frame_sum (d_frame_sum),
    .frame_done(d_frame_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    rst = 1'b0;
    step = 1'b1;
    u_s_if.tvalid = 1'b0;
    u_s_if.tdata  = '0;
    u_m_if.tready = 1'b0;

    // reset, with step high to show rst wins
    cyc();
    chk("rst_s_tready", u_s_if.tready, 0);
    chk("rst_m_tvalid", u_m_if.tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_m_tdata", u_m_if.tdata, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    cyc();
    rst = 1'b1;
    #1;
    chk("post_rst_s_tready", u_s_if.tready, 1);
    chk("post_rst_m_tvalid", u_m_if.tvalid, 0);
    chk("post_rst_frame_cnt", frame_cnt, 0);
    cyc();

    // streaming, one pixel per cycle
    u_m_if.tready = 1'b1;
    for (int k = 0; k <= 980; k++) begin
      if (k > 0) begin
        e = 8'(16 + k - 1);
        chk("stream_valid", u_m_if.tvalid, 1);
        chk("stream_data", u_m_if.tdata, e);
        chk("stream_last", m_tlast, ((k - 1) % 4) == 3);
        chk("stream_user", m_tuser, ((k - 1) % 8) == 0);
        chk("stream_d_data", d_m_tdata, e);
        chk("stream_d_last", d_m_tlast, ((k - 1) % 488) == 487);
        chk("stream_d_user", d_m_tuser, (k - 1) == 0);
      end
      chk("stream_s_tready", u_s_if.tready, 1);
      if (k < 980) begin
        u_s_if.tvalid = 1'b1;
        u_s_if.tdata  = 8'(16 + k);
      end else begin
        u_s_if.tvalid = 1'b0;
      end
      cyc();
    end
    chk("stream_drained", u_m_if.tvalid, 0);
    chk("stream_frame_cnt", frame_cnt, 122);
    chk("stream_d_frame_cnt", d_frame_cnt, 0);

    // frame wrap on the 4x2 instance
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) begin
        e = 8'(8'hA0 + k - 1);
        chk("wrap_data", u_m_if.tdata, e);
        chk("wrap_user", m_tuser, (k - 1) == 0 || (k - 1) == 8);
        chk("wrap_last", m_tlast, ((k - 1) % 4) == 3);
        chk("wrap_frame_cnt", frame_cnt, (k - 1) >= 8 ? 1 : 0);
      end
      if (k < 9) begin
        u_s_if.tvalid = 1'b1;
        u_s_if.tdata  = 8'(8'hA0 + k);
      end else begin
        u_s_if.tvalid = 1'b0;
      end
      cyc();
    end
    chk("wrap_final_cnt", frame_cnt, 1);

    // backpressure: next pixels land at x=1,2,3
    u_m_if.tready = 1'b0;
    u_s_if.tvalid = 1'b1;
    u_s_if.tdata  = 8'h55;
    #1;
    chk("bp_s_tready0", u_s_if.tready, 1);
    cyc();
    chk("bp_valid1", u_m_if.tvalid, 1);
    chk("bp_data1", u_m_if.tdata, 8'h55);
    chk("bp_s_tready1", u_s_if.tready, 1);
    u_s_if.tdata = 8'h66;
    cyc();
    chk("bp_s_tready_full", u_s_if.tready, 0);
    chk("bp_data_hold", u_m_if.tdata, 8'h55);
    chk("bp_last_hold", m_tlast, 0);
    u_s_if.tdata = 8'h77;
    cyc();
    chk("bp_s_tready_full2", u_s_if.tready, 0);
    chk("bp_data_hold2", u_m_if.tdata, 8'h55);
    chk("bp_valid_hold", u_m_if.tvalid, 1);
    u_m_if.tready = 1'b1;
    cyc();
    chk("bp_drain_66", u_m_if.tdata, 8'h66);
    chk("bp_s_tready_free", u_s_if.tready, 1);
    chk("bp_last_66", m_tlast, 0);
    cyc();
    chk("bp_drain_77", u_m_if.tdata, 8'h77);
    chk("bp_last_77", m_tlast, 1);
    chk("bp_valid_77", u_m_if.tvalid, 1);
    u_s_if.tvalid = 1'b0;
    cyc();
    chk("bp_empty", u_m_if.tvalid, 0);

    // step freeze mid-line, then reset at x=3
    u_s_if.tvalid = 1'b1;
    u_s_if.tdata  = 8'h01;
    cyc();
    chk("st_data01", u_m_if.tdata, 8'h01);
    chk("st_user01", m_tuser, 0);
    u_s_if.tdata = 8'h02;
    cyc();
    chk("st_data02", u_m_if.tdata, 8'h02);
    step = 1'b0;
    u_s_if.tdata = 8'h03;
    #1;
    chk("st_off_s_tready", u_s_if.tready, 0);
    chk("st_off_m_tvalid", u_m_if.tvalid, 0);
    chk("st_off_m_tlast", m_tlast, 0);
    chk("st_off_m_tuser", m_tuser, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("st_frozen_s_tready", u_s_if.tready, 0);
      chk("st_frozen_m_tvalid", u_m_if.tvalid, 0);
      chk("st_frozen_frame_cnt", frame_cnt, 1);
    end
    step = 1'b1;
    #1;
    chk("st_on_valid", u_m_if.tvalid, 1);
    chk("st_on_data02", u_m_if.tdata, 8'h02);
    chk("st_on_last02", m_tlast, 0);
    cyc();
    chk("st_data03", u_m_if.tdata, 8'h03);
    chk("st_last03", m_tlast, 0);
    u_s_if.tdata = 8'h04;
    cyc();
    chk("st_data04", u_m_if.tdata, 8'h04);
    chk("st_last04", m_tlast, 1);
    rst = 1'b0;
    u_s_if.tvalid = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", u_m_if.tvalid, 0);
    chk("mid_rst_s_tready", u_s_if.tready, 0);
    cyc();
    rst = 1'b1;
    u_s_if.tvalid = 1'b1;
    u_s_if.tdata  = 8'h05;
    #1;
    chk("mid_rst_discard", u_m_if.tvalid, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_tdata", u_m_if.tdata, 0);
    cyc();
    chk("mid_rst_data05", u_m_if.tdata, 8'h05);
    chk("mid_rst_user05", m_tuser, 1);
    u_s_if.tvalid = 1'b0;
    cyc();
    chk("mid_rst_empty", u_m_if.tvalid, 0);

`ifdef GB_OUT_FRAMER_CKSUM_EN
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("ck_rst_sum", frame_sum, 0);
    chk("ck_rst_done", frame_done, 0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) chk("ck_done_low", frame_done, 0);
      u_s_if.tvalid = (k < 8);
      u_s_if.tdata  = 8'hFF;
      cyc();
    end
    chk("ck_done_pulse", frame_done, 1);
    chk("ck_sum", frame_sum, 16'h07F8);
    cyc();
    chk("ck_done_cleared", frame_done, 0);
    chk("ck_sum_held", frame_sum, 16'h07F8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
